// File: rtl/axi_atop_reject_pkg.sv
// Shared AXI channel payloads and constants for the atomic-reject stage.
// Defines the default request/response structs used on both AXI ports.
package axi_atop_reject_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  // atop bit that marks an atomic needing a read response
  localparam int unsigned ATOP_R_RESP = 5;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [5:0]           atop;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_atop_reject.sv
// Terminates AXI5 atomic writes locally: absorbs their W beats, answers with
// a SLVERR B and, for atomics that return data, len+1 SLVERR R beats.
// Non-atomic traffic and the AR channel pass straight through.
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   slv_req_i   upstream request
//   slv_resp_o  upstream response
//   mst_req_o   downstream request (toward the atop-zeroing stage)
//   mst_resp_i  downstream response
module axi_atop_reject #(
  parameter int unsigned AxiIdWidth      = 4,
  parameter int unsigned AxiMaxWriteTxns = 8,
  parameter type axi_req_t  = axi_atop_reject_pkg::axi_req_t,
  parameter type axi_resp_t = axi_atop_reject_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);
  import axi_atop_reject_pkg::*;

  localparam int unsigned CntWidth = $clog2(AxiMaxWriteTxns + 1);

  typedef enum logic [1:0] {IDLE, ABSORB_W, INJ_B, INJ_R} state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   w_cnt_q, w_cnt_d;
  logic                  r_busy_q, r_busy_d;
  logic                  b_lock_q, b_lock_d;
  logic                  r_lock_q, r_lock_d;
  logic [AxiIdWidth-1:0] id_q, id_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic                  need_r_q, need_r_d;
  logic                  is_atop;

  assign is_atop = |slv_req_i.aw.atop;

  // Channel routing, FSM next state and bookkeeping
  always_comb begin
    logic b_inj;
    logic r_inj;
    logic aw_fwd_hs;
    logic w_last_hs;

    state_d    = state_q;
    w_cnt_d    = w_cnt_q;
    r_busy_d   = r_busy_q;
    b_lock_d   = b_lock_q;
    r_lock_d   = r_lock_q;
    id_d       = id_q;
    len_d      = len_q;
    beat_d     = beat_q;
    need_r_d   = need_r_q;
    mst_req_o  = slv_req_i;
    slv_resp_o = mst_resp_i;

    // AW: atomics only start with no forwarded write still owing W beats
    mst_req_o.aw_valid  = 1'b0;
    slv_resp_o.aw_ready = 1'b0;
    if (state_q == IDLE) begin
      if (is_atop) begin
        slv_resp_o.aw_ready = (w_cnt_q == '0);
      end else if (w_cnt_q < CntWidth'(AxiMaxWriteTxns)) begin
        mst_req_o.aw_valid  = slv_req_i.aw_valid;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready;
      end
    end

    // W: forwarded bursts first, then absorb the atomic's beats
    mst_req_o.w_valid  = 1'b0;
    slv_resp_o.w_ready = 1'b0;
    if (w_cnt_q != '0) begin
      mst_req_o.w_valid  = slv_req_i.w_valid;
      slv_resp_o.w_ready = mst_resp_i.w_ready;
    end else if (state_q == ABSORB_W) begin
      slv_resp_o.w_ready = 1'b1;
    end

    // B: inject only once no downstream B is half-presented upstream
    b_inj = (state_q == INJ_B) && !b_lock_q;
    if (b_inj) begin
      slv_resp_o.b_valid = 1'b1;
      slv_resp_o.b.id    = id_q;
      slv_resp_o.b.resp  = RESP_SLVERR;
      mst_req_o.b_ready  = 1'b0;
    end

    // R: inject only between downstream bursts
    r_inj = (state_q == INJ_R) && !r_lock_q && !r_busy_q;
    if (r_inj) begin
      slv_resp_o.r_valid = 1'b1;
      slv_resp_o.r.id    = id_q;
      slv_resp_o.r.data  = '0;
      slv_resp_o.r.resp  = RESP_SLVERR;
      slv_resp_o.r.last  = (beat_q == len_q);
      mst_req_o.r_ready  = 1'b0;
    end

    // No handshake on either side while in reset
    if (rst_i) begin
      mst_req_o.aw_valid  = 1'b0;
      mst_req_o.w_valid   = 1'b0;
      mst_req_o.b_ready   = 1'b0;
      mst_req_o.ar_valid  = 1'b0;
      mst_req_o.r_ready   = 1'b0;
      slv_resp_o.aw_ready = 1'b0;
      slv_resp_o.w_ready  = 1'b0;
      slv_resp_o.b_valid  = 1'b0;
      slv_resp_o.ar_ready = 1'b0;
      slv_resp_o.r_valid  = 1'b0;
    end

    // Outstanding forwarded writes still owing their W last
    aw_fwd_hs = mst_req_o.aw_valid && mst_resp_i.aw_ready;
    w_last_hs = mst_req_o.w_valid && mst_resp_i.w_ready && mst_req_o.w.last;
    if (aw_fwd_hs && !w_last_hs) begin
      w_cnt_d = w_cnt_q + CntWidth'(1);
    end else if (!aw_fwd_hs && w_last_hs) begin
      w_cnt_d = w_cnt_q - CntWidth'(1);
    end

    // Pass-through B/R presented but not yet taken must finish first
    if (!b_inj) begin
      b_lock_d = slv_resp_o.b_valid && !slv_req_i.b_ready;
    end
    if (!r_inj) begin
      r_lock_d = slv_resp_o.r_valid && !slv_req_i.r_ready;
      if (slv_resp_o.r_valid && slv_req_i.r_ready) begin
        r_busy_d = !slv_resp_o.r.last;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (is_atop && slv_req_i.aw_valid && slv_resp_o.aw_ready) begin
          id_d     = AxiIdWidth'(slv_req_i.aw.id);
          len_d    = slv_req_i.aw.len;
          need_r_d = slv_req_i.aw.atop[ATOP_R_RESP];
          state_d  = ABSORB_W;
        end
      end
      ABSORB_W: begin
        if (slv_req_i.w_valid && slv_resp_o.w_ready && slv_req_i.w.last) begin
          state_d = INJ_B;
        end
      end
      INJ_B: begin
        if (b_inj && slv_req_i.b_ready) begin
          beat_d  = '0;
          state_d = need_r_q ? INJ_R : IDLE;
        end
      end
      INJ_R: begin
        if (r_inj && slv_req_i.r_ready) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      w_cnt_q  <= '0;
      r_busy_q <= 1'b0;
      b_lock_q <= 1'b0;
      r_lock_q <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      need_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_cnt_q  <= w_cnt_d;
      r_busy_q <= r_busy_d;
      b_lock_q <= b_lock_d;
      r_lock_q <= r_lock_d;
      id_q     <= id_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      need_r_q <= need_r_d;
    end
  end

endmodule

// File: tb/tb_axi_atop_reject.sv
// Self-checking bench for axi_atop_reject: directed scenarios plus a
// randomized run of atomics against a small expectation model.
module tb_axi_atop_reject;
  import axi_atop_reject_pkg::*;

  localparam int unsigned MaxTxns = 2;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  slv_req;
  axi_resp_t slv_resp;
  axi_req_t  mst_req;
  axi_resp_t mst_resp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_atop_reject #(
    .AxiIdWidth     (4),
    .AxiMaxWriteTxns(MaxTxns),
    .axi_req_t      (axi_req_t),
    .axi_resp_t     (axi_resp_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic aw_chan_t mk_aw(input logic [3:0] id, input logic [7:0] len,
                                     input logic [5:0] atop);
    aw_chan_t a;
    a.id    = id;
    a.addr  = $urandom;
    a.len   = len;
    a.size  = 3'd2;
    a.burst = 2'b01;
    a.atop  = atop;
    return a;
  endfunction

  // Non-atomic AW must appear downstream unchanged
  task automatic fwd_aw(input logic [3:0] id, input logic [7:0] len);
    aw_chan_t a;
    a = mk_aw(id, len, 6'd0);
    slv_req.aw = a;
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    settle();
    chk("aw_fwd_valid", 64'(mst_req.aw_valid), 64'(1));
    chk("aw_fwd_payload", 64'(mst_req.aw), 64'(a));
    chk("aw_fwd_ready", 64'(slv_resp.aw_ready), 64'(1));
    cyc();
    slv_req.aw_valid = 1'b0;
    mst_resp.aw_ready = 1'b0;
  endtask

  task automatic w_pass(input logic last);
    w_chan_t w;
    w.data = $urandom;
    w.strb = 4'hf;
    w.last = last;
    slv_req.w = w;
    slv_req.w_valid = 1'b1;
    mst_resp.w_ready = 1'b1;
    settle();
    chk("w_fwd_valid", 64'(mst_req.w_valid), 64'(1));
    chk("w_fwd_payload", 64'(mst_req.w), 64'(w));
    chk("w_fwd_ready", 64'(slv_resp.w_ready), 64'(1));
    cyc();
    slv_req.w_valid = 1'b0;
    mst_resp.w_ready = 1'b0;
  endtask

  task automatic b_pass(input logic [3:0] id);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id = id;
    mst_resp.b.resp = 2'b00;
    slv_req.b_ready = 1'b1;
    settle();
    chk("b_pass_valid", 64'(slv_resp.b_valid), 64'(1));
    chk("b_pass_payload", 64'({slv_resp.b.id, slv_resp.b.resp}), 64'({id, 2'b00}));
    chk("b_pass_ready", 64'(mst_req.b_ready), 64'(1));
    cyc();
    mst_resp.b_valid = 1'b0;
    slv_req.b_ready = 1'b0;
  endtask

  task automatic r_pass(input logic [3:0] id, input logic last);
    r_chan_t r;
    r.id = id;
    r.data = $urandom;
    r.resp = 2'b00;
    r.last = last;
    mst_resp.r = r;
    mst_resp.r_valid = 1'b1;
    slv_req.r_ready = 1'b1;
    settle();
    chk("r_pass_valid", 64'(slv_resp.r_valid), 64'(1));
    chk("r_pass_payload", 64'(slv_resp.r), 64'(r));
    chk("r_pass_ready", 64'(mst_req.r_ready), 64'(1));
    cyc();
    mst_resp.r_valid = 1'b0;
    slv_req.r_ready = 1'b0;
  endtask

  // Expected injected read: len+1 SLVERR beats, zero data, last on final beat
  task automatic expect_inj_r(input logic [3:0] id, input logic [7:0] len);
    r_chan_t exp_r;
    for (int k = 0; k <= int'(len); k++) begin
      exp_r.id = id;
      exp_r.data = '0;
      exp_r.resp = 2'b10;
      exp_r.last = (k == int'(len));
      slv_req.r_ready = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        settle();
        chk("inj_r_hold", 64'(slv_resp.r_valid), 64'(1));
        cyc();
      end
      slv_req.r_ready = 1'b1;
      settle();
      chk("inj_r_valid", 64'(slv_resp.r_valid), 64'(1));
      chk("inj_r_payload", 64'(slv_resp.r), 64'(exp_r));
      chk("inj_r_no_mst_ready", 64'(mst_req.r_ready), 64'(0));
      cyc();
    end
    slv_req.r_ready = 1'b0;
  endtask

  // Full atomic: absorbed W, SLVERR B, optional injected R
  task automatic atomic(input logic [3:0] id, input logic [7:0] len,
                        input logic [5:0] atop, input bit do_r);
    bit need_r;
    int waits;
    need_r = atop[5];
    slv_req.aw = mk_aw(id, len, atop);
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    settle();
    chk("atop_aw_ready", 64'(slv_resp.aw_ready), 64'(1));
    chk("atop_no_fwd", 64'(mst_req.aw_valid), 64'(0));
    cyc();
    slv_req.aw_valid = 1'b0;
    mst_resp.aw_ready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if ($urandom_range(0, 1) == 0) cyc();
      slv_req.w.data = $urandom;
      slv_req.w.strb = 4'hf;
      slv_req.w.last = (b == int'(len));
      slv_req.w_valid = 1'b1;
      mst_resp.w_ready = 1'b1;
      settle();
      chk("absorb_w_ready", 64'(slv_resp.w_ready), 64'(1));
      chk("absorb_no_fwd", 64'(mst_req.w_valid), 64'(0));
      cyc();
      slv_req.w_valid = 1'b0;
      mst_resp.w_ready = 1'b0;
    end
    waits = $urandom_range(0, 2);
    for (int i = 0; i < waits; i++) begin
      settle();
      chk("inj_b_hold", 64'(slv_resp.b_valid), 64'(1));
      cyc();
    end
    slv_req.b_ready = 1'b1;
    settle();
    chk("inj_b_valid", 64'(slv_resp.b_valid), 64'(1));
    chk("inj_b_payload", 64'({slv_resp.b.id, slv_resp.b.resp}), 64'({id, 2'b10}));
    chk("inj_b_no_mst_ready", 64'(mst_req.b_ready), 64'(0));
    cyc();
    slv_req.b_ready = 1'b0;
    if (do_r) begin
      if (need_r) expect_inj_r(id, len);
      settle();
      chk("atop_done_r", 64'(slv_resp.r_valid), 64'(0));
      chk("atop_done_b", 64'(slv_resp.b_valid), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rid;
    logic [7:0] rlen;
    logic [5:0] ratop;
    ar_chan_t   ar;
    slv_req  = '0;
    mst_resp = '0;
    rst      = 1'b1;

    // Reset: all valid/ready outputs held low even with active inputs
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid = 1'b1;
    slv_req.ar_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.b_valid = 1'b1;
    mst_resp.r_valid = 1'b1;
    settle();
    chk("rst_mst_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    chk("rst_slv_aw_ready", 64'(slv_resp.aw_ready), 64'(0));
    chk("rst_mst_ar_valid", 64'(mst_req.ar_valid), 64'(0));
    chk("rst_slv_b_valid", 64'(slv_resp.b_valid), 64'(0));
    chk("rst_slv_r_valid", 64'(slv_resp.r_valid), 64'(0));
    cyc();
    cyc();
    rst = 1'b0;
    slv_req = '0;
    mst_resp = '0;
    settle();
    chk("idle_w_ready", 64'(slv_resp.w_ready), 64'(0));
    chk("idle_b_valid", 64'(slv_resp.b_valid), 64'(0));
    slv_req.aw.atop = 6'b010000;
    settle();
    chk("idle_atop_ready", 64'(slv_resp.aw_ready), 64'(1));
    slv_req.aw.atop = 6'd0;
    cyc();

    // 1: non-atomic write id=3 len=3, then read len=1
    fwd_aw(4'd3, 8'd3);
    for (int k = 0; k < 4; k++) w_pass(k == 3);
    b_pass(4'd3);
    ar.id = 4'd3; ar.addr = $urandom; ar.len = 8'd1; ar.size = 3'd2; ar.burst = 2'b01;
    slv_req.ar = ar;
    slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b1;
    settle();
    chk("ar_fwd_payload", 64'(mst_req.ar), 64'(ar));
    chk("ar_fwd_valid", 64'(mst_req.ar_valid), 64'(1));
    chk("ar_fwd_ready", 64'(slv_resp.ar_ready), 64'(1));
    cyc();
    slv_req.ar_valid = 1'b0;
    mst_resp.ar_ready = 1'b0;
    r_pass(4'd3, 1'b0);
    r_pass(4'd3, 1'b1);

    // 2: AtomicStore, no R
    atomic(4'd5, 8'd0, 6'b010000, 1'b1);
    // 3: AtomicSwap len=1, two R beats
    atomic(4'd2, 8'd1, 6'b110000, 1'b1);

    // 4: full forwarded-write table blocks AW; atomic waits for W drain
    fwd_aw(4'd1, 8'd0);
    fwd_aw(4'd4, 8'd0);
    slv_req.aw = mk_aw(4'd6, 8'd0, 6'd0);
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    settle();
    chk("aw_full_ready", 64'(slv_resp.aw_ready), 64'(0));
    chk("aw_full_no_fwd", 64'(mst_req.aw_valid), 64'(0));
    slv_req.aw = mk_aw(4'd9, 8'd0, 6'b100000);
    settle();
    chk("atop_wait_w1", 64'(slv_resp.aw_ready), 64'(0));
    w_pass(1'b1);
    settle();
    chk("atop_wait_w2", 64'(slv_resp.aw_ready), 64'(0));
    w_pass(1'b1);
    settle();
    chk("atop_after_drain", 64'(slv_resp.aw_ready), 64'(1));
    slv_req.aw_valid = 1'b0;
    atomic(4'd9, 8'd0, 6'b100000, 1'b1);
    b_pass(4'd1);
    b_pass(4'd4);

    // 5: downstream R burst in flight when INJ_R is entered
    r_pass(4'd7, 1'b0);
    atomic(4'd8, 8'd1, 6'b110000, 1'b0);
    settle();
    chk("inj_r_wait_busy", 64'(slv_resp.r_valid), 64'(0));
    cyc();
    for (int k = 1; k <= 3; k++) r_pass(4'd7, k == 3);
    expect_inj_r(4'd8, 8'd1);
    settle();
    chk("inj_r_done", 64'(slv_resp.r_valid), 64'(0));

    // 6: reset during ABSORB_W
    slv_req.aw = mk_aw(4'd10, 8'd3, 6'b100000);
    slv_req.aw_valid = 1'b1;
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.w.last = 1'b0;
    slv_req.w_valid = 1'b1;
    settle();
    chk("absorb_before_rst", 64'(slv_resp.w_ready), 64'(1));
    cyc();
    rst = 1'b1;
    slv_req.aw = mk_aw(4'd11, 8'd0, 6'd0);
    slv_req.aw_valid = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready = 1'b1;
    settle();
    chk("rst2_w_ready", 64'(slv_resp.w_ready), 64'(0));
    chk("rst2_mst_aw_valid", 64'(mst_req.aw_valid), 64'(0));
    chk("rst2_mst_w_valid", 64'(mst_req.w_valid), 64'(0));
    cyc();
    rst = 1'b0;
    slv_req.aw_valid = 1'b0;
    mst_resp.aw_ready = 1'b0;
    settle();
    chk("post_rst_no_absorb", 64'(slv_resp.w_ready), 64'(0));
    chk("post_rst_b_valid", 64'(slv_resp.b_valid), 64'(0));
    slv_req.w_valid = 1'b0;
    mst_resp.w_ready = 1'b0;
    cyc();
    fwd_aw(4'd11, 8'd0);
    w_pass(1'b1);
    b_pass(4'd11);

    // Randomized atomics of every flavour
    for (int t = 0; t < 10; t++) begin
      rid  = 4'($urandom);
      rlen = 8'($urandom_range(0, 5));
      case ($urandom_range(0, 3))
        0: ratop = 6'b010000 | 6'($urandom_range(0, 15));
        1: ratop = 6'b100000 | 6'($urandom_range(0, 15));
        2: ratop = 6'b110000;
        default: ratop = 6'b110001;
      endcase
      atomic(rid, rlen, ratop, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
